dmem_responder: RTL

- Data-memory responder on the far end of the MemRead/MemWrite control interface driven by the control unit.
- Services RV32I loads and stores (byte/half/word, signed/unsigned) from an internal word array with a configurable access latency.
- Holds the core with a stall output until each access completes.
- Sits between the EX/MEM stage and the MemToReg write-back mux.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 46 ++++
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds funct3 access codes, the FSM state encoding and the alignment check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // Unsupported encodings are rejected the same way as misaligned ones
    function automatic logic f3_bad(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the EX/MEM stage and the data memory.
// The core is the master; dmem_responder is the slave.
interface dmem_if;

    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        misaligned;

    modport master (
        output MemRead, MemWrite, funct3, addr, wdata,
        input  rdata, rvalid, stall, misaligned
    );

    modport slave (
        input  MemRead, MemWrite, funct3, addr, wdata,
        output rdata, rvalid, stall, misaligned
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extraction/extension and store byte enables.
// Purely combinational; funct3[1:0] is the size, funct3[2] means unsigned.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        uns;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        uns      = funct3_i[2];
        load_o   = word_i;
        be_o     = 4'b0000;
        wword_o  = wdata_i;
        unique case (1'b1)
            funct3_i[1:0] == 2'b00: begin
                load_o  = {{24{byte_sel[7] & ~uns}}, byte_sel};
                be_o    = 4'b0001 << lane_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            funct3_i[1:0] == 2'b01: begin
                load_o  = {{16{half_sel[15] & ~uns}}, half_sel};
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            funct3_i[1:0] == 2'b10: begin
                load_o  = word_i;
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RV32I loads/stores with LATENCY wait cycles and stall.
// DMEM_ACCESS_COUNT_EN adds rd_count/wr_count completed-access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_if.slave       bus
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int IW     = AW + 2;
    localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   a_q, a_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     wd_q, wd_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            mis_q, mis_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            bad;
    logic            in_wait;
    logic            acc;
    logic            stall_c;
    logic            mem_we;
    logic [IW-1:0]   acc_a;
    logic [2:0]      acc_f3;
    logic [31:0]     acc_wd;
    logic            acc_wr;
    logic [31:0]     word;
    logic [31:0]     ld;
    logic [3:0]      be;
    logic [31:0]     ww;
    logic            unused_addr;

    assign req         = bus.MemRead | bus.MemWrite;
    assign bad         = f3_bad(bus.funct3, bus.addr[1:0]);
    assign unused_addr = ^(bus.addr >> IW);

    // WAIT works from the latched request; IDLE (LATENCY=0) uses the live one
    assign in_wait = (state_q == WAIT);
    assign acc_a   = in_wait ? a_q  : bus.addr[IW-1:0];
    assign acc_f3  = in_wait ? f3_q : bus.funct3;
    assign acc_wd  = in_wait ? wd_q : bus.wdata;
    assign acc_wr  = in_wait ? wr_q : bus.MemWrite;
    assign word    = mem[acc_a[IW-1:2]];

    dmem_lane_align u_align (
        .word_i   (word),
        .lane_i   (acc_a[1:0]),
        .funct3_i (acc_f3),
        .wdata_i  (acc_wd),
        .load_o   (ld),
        .be_o     (be),
        .wword_o  (ww)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        f3_d     = f3_q;
        wd_d     = wd_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        mis_d    = 1'b0;
        stall_c  = 1'b0;
        acc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else if (LATENCY == 0) begin
                        acc = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        a_d     = bus.addr[IW-1:0];
                        f3_d    = bus.funct3;
                        wd_d    = bus.wdata;
                        wr_d    = bus.MemWrite;
                        cnt_d   = CW'(LAT_M1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    acc     = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (acc) begin
            rvalid_d = 1'b1;
            rdata_d  = acc_wr ? 32'h0 : ld;
        end
    end

    assign mem_we = acc & acc_wr & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            f3_q     <= '0;
            wd_q     <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            f3_q     <= f3_d;
            wd_q     <= wd_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            mis_q    <= mis_d;
        end
    end

    // Array has no reset; only enabled lanes are written
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[acc_a[IW-1:2]][8*b +: 8] <= ww[8*b +: 8];
            end
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.misaligned = mis_q;
    assign bus.stall      = stall_c;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (acc && !acc_wr) rd_cnt_d = rd_cnt_q + 32'd1;
        if (acc && acc_wr)  wr_cnt_d = wr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
